pwm_multi_deadtime: RTL and testbench
=====================================

// Module: pwm_multi_deadtime
// PURPOSE
// Multi-channel PWM generator for the gate driver. Each channel drives a complementary hi/lo pair with programmable dead time.
// All channels share one free-running carrier counter, so they are phase-aligned and glitch-free.
// Duty updates arrive over a valid/ready write port (e.g. from the UART command path). They land in shadow registers.
// Shadow values take effect only at period boundaries.
// PARAMETERS
// N         8  counter/duty width; period = 2^N steps
// CHANNELS  2  number of independent PWM channels (>=1)
// DT_W      4  width of dead-time count (clk cycles)
// PORTS
// clk            in   1                      system clock, all logic on posedge
// rst_n          in   1                      asynchronous active-low reset
// ena            in   1                      global enable; low forces all outputs low
// step           in   1                      counter advance strobe (prescaler tick)
// dead_time      in   DT_W                   dead-time length in clk cycles
// duty_wr_valid  in   1                      duty write request
// duty_wr_ready  out  1                      write accepted when valid&ready
// duty_wr_ch     in   $clog2(CHANNELS)(min 1) target channel
// duty_wr_data   in   N                      new duty value
// pwm_hi         out  CHANNELS               high-side gate command per channel
// pwm_lo         out  CHANNELS               low-side gate command per channel
// period_sync    out  1                      1-clk pulse when counter wraps to 0
// BEHAVIOUR
// - Reset: cnt=0, shadow/active duty=0, dead timers=0, pwm_hi=pwm_lo=0, period_sync=0, duty_wr_ready=0.
// - duty_wr_ready=1 from the first clk after reset release.
// - Write: on valid&ready, shadow[duty_wr_ch] <= duty_wr_data. Writes with ch>=CHANNELS are accepted and dropped.
// - Counter: when ena&step, cnt <= cnt+1, wrapping 2^N-1 -> 0; this wrap is the period boundary.
// - Counter hold: when !ena, cnt is forced to 0; step is ignored.
// - period_sync: pulses 1 clk in the cycle cnt becomes 0 via wrap.
// - Boundary latch: in the cycle cnt becomes 0 via wrap, active_duty[i] <= shadow[i] and active dead time <= dead_time.
// - Boundary write: a write in that same cycle lands in shadow and applies at the next boundary.
// - Enable latch: the same latch happens in the first clk that ena is high after being low.
// - Compare: raw[i] = (active_duty==2^N-1) ? 1 : (cnt < active_duty). duty 0 gives constant 0; duty 2^N-1 gives constant 1.
// - Dead-time FSM per channel: states OFF, DEAD, HI, LO.
//   - OFF: entered on reset or !ena; both outputs 0. When ena is high, go to DEAD with target=raw.
//   - DEAD: both outputs 0; timer counts active dead time in clk cycles.
//     - Timer expiry goes to HI if target=1, else LO.
//     - If raw changes while in DEAD, set target=raw and restart the timer.
//   - HI (pwm_hi=1) / LO (pwm_lo=1): when raw differs from the current side, go to DEAD with target=raw.
//   - Active dead time 0: the DEAD phase is skipped; the side swaps directly, 1 clk after the raw change.
// - Latency: pwm_hi/pwm_lo are registered. An output asserts active_dead_time+1 clk after the clk in which raw changed.
// - Invariant: pwm_hi[i] & pwm_lo[i] is never 1, in any state, including across ena toggles and reset.
// - ena low mid-period: next clk all outputs 0, FSMs go to OFF, cnt=0. Shadow registers are retained.
// - rst_n asserted mid-operation: all outputs drop asynchronously to 0. Nothing glitches high on release.
// TESTING
// - Reset: rst_n=0 with ena=1,step=1 -> pwm_hi=pwm_lo=0, period_sync=0, duty_wr_ready=0.
//   Release -> duty_wr_ready=1 next clk.
// - N=8, step=1, dead_time=0, write ch0 duty=64 -> from the next boundary, pwm_hi[0] is high 64 of 256 clks.
//   pwm_lo[0] is high the other 192; period_sync every 256 clks.
// - dead_time=3, duty=128 -> both outputs low for exactly 3 clks at each edge.
//   pwm_hi is high 125 clks per period; hi&lo never both 1.
// - Write duty=0 then duty=255 on ch1 mid-period -> no change until the wrap.
//   duty=0 gives lo constant 1; duty=255 gives hi constant 1, no dead-time gaps in steady state.
// - Drop ena at cnt=100 -> all outputs 0 next clk, cnt=0.
//   Raise ena -> dead_time clks both low, then the side given by raw.
// - Step every 4th clk, write duty=10 to ch>=CHANNELS -> write dropped, period=1024 clks.
//   Existing duties are unchanged.

Source files
------------

// File: rtl/pwm_multi_deadtime.sv
// Multi-channel complementary PWM with a shared carrier counter, shadowed duty
// registers that apply at period boundaries, and per-channel dead-time insertion.
module pwm_multi_deadtime #(
  parameter int unsigned N        = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DT_W     = 4,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                step,
  input  logic [DT_W-1:0]     dead_time,
  input  logic                duty_wr_valid,
  output logic                duty_wr_ready,
  input  logic [CW-1:0]       duty_wr_ch,
  input  logic [N-1:0]        duty_wr_data,
  output logic [CHANNELS-1:0] pwm_hi,
  output logic [CHANNELS-1:0] pwm_lo,
  output logic                period_sync
);

  typedef enum logic [1:0] {StOff, StDead, StHi, StLo} state_e;

  localparam logic [N-1:0] CntMax = '1;

  logic [N-1:0]    cnt_q;
  logic            ena_q, ready_q, sync_q;
  logic [DT_W-1:0] dt_q, dt_eff;
  logic            wrap, latch, wr_en;

  assign wrap   = ena & step & (cnt_q == CntMax);
  assign latch  = wrap | (ena & ~ena_q);
  // A dead phase started in a latch cycle uses the incoming dead time, not the stale one.
  assign dt_eff = latch ? dead_time : dt_q;
  assign wr_en  = duty_wr_valid & ready_q & (32'(duty_wr_ch) < CHANNELS);

  assign duty_wr_ready = ready_q;
  assign period_sync   = sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      ready_q <= 1'b0;
      sync_q  <= 1'b0;
      dt_q    <= '0;
    end else begin
      ena_q   <= ena;
      ready_q <= 1'b1;
      sync_q  <= wrap;
      if (!ena) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + N'(1);
      end
      if (latch) begin
        dt_q <= dead_time;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [N-1:0]    shadow_q, duty_q;
    logic            raw, restart;
    logic            target_q, target_d;
    logic            hi_q, lo_q;
    logic [DT_W-1:0] timer_q, timer_d;
    state_e          state_q, state_d;

    assign raw = (duty_q == CntMax) | (cnt_q < duty_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        duty_q   <= '0;
      end else begin
        if (wr_en && duty_wr_ch == CW'(i)) begin
          shadow_q <= duty_wr_data;
        end
        if (latch) begin
          duty_q <= shadow_q;
        end
      end
    end

    always_comb begin
      restart  = 1'b0;
      state_d  = state_q;
      target_d = target_q;
      timer_d  = timer_q;
      case (state_q)
        StOff:   restart = 1'b1;
        StDead:  restart = (raw != target_q);
        StHi:    restart = ~raw;
        StLo:    restart = raw;
        default: restart = 1'b1;
      endcase
      if (!ena) begin
        state_d = StOff;
        timer_d = '0;
      end else if (restart) begin
        // Timer holds remaining dead cycles after this one; zero dead time swaps sides directly.
        target_d = raw;
        timer_d  = dt_eff - DT_W'(1);
        state_d  = (dt_eff == '0) ? (raw ? StHi : StLo) : StDead;
      end else if (state_q == StDead) begin
        if (timer_q == '0) begin
          state_d = target_q ? StHi : StLo;
        end else begin
          timer_d = timer_q - DT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= StOff;
        target_q <= 1'b0;
        timer_q  <= '0;
        hi_q     <= 1'b0;
        lo_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        target_q <= target_d;
        timer_q  <= timer_d;
        hi_q     <= (state_d == StHi);
        lo_q     <= (state_d == StLo);
      end
    end

    assign pwm_hi[i] = hi_q;
    assign pwm_lo[i] = lo_q;
  end

endmodule

// File: tb/tb_pwm_multi_deadtime.sv
// Randomized and directed bench for pwm_multi_deadtime, checked against a
// timestamp-based behavioural model of the carrier, shadow latching and dead time.
module tb_pwm_multi_deadtime;

  localparam int N      = 8;
  localparam int CH     = 3;
  localparam int DTW    = 4;
  localparam int CntMax = (1 << N) - 1;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          step;
  logic [DTW-1:0] dead_time;
  logic          duty_wr_valid;
  logic          duty_wr_ready;
  logic [1:0]    duty_wr_ch;
  logic [N-1:0]  duty_wr_data;
  logic [CH-1:0] pwm_hi;
  logic [CH-1:0] pwm_lo;
  logic          period_sync;

  pwm_multi_deadtime #(
    .N        (N),
    .CHANNELS (CH),
    .DT_W     (DTW)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .step          (step),
    .dead_time     (dead_time),
    .duty_wr_valid (duty_wr_valid),
    .duty_wr_ready (duty_wr_ready),
    .duty_wr_ch    (duty_wr_ch),
    .duty_wr_data  (duty_wr_data),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .period_sync   (period_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int step_div;
  int cyc_cnt;

  // Reference model: outputs follow the last raw change once its dead time has elapsed.
  int m_cnt, m_dt, m_edge;
  bit m_ena_q, m_ready, m_sync;
  int m_shadow[CH];
  int m_duty[CH];
  bit m_off[CH];
  bit m_last[CH];
  int m_chg[CH];
  int m_chg_dt[CH];
  bit m_hi[CH];
  bit m_lo[CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dt = 0; m_edge = 0;
    m_ena_q = 0; m_ready = 0; m_sync = 0;
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = 0; m_duty[c] = 0; m_off[c] = 1; m_last[c] = 0;
      m_chg[c] = 0; m_chg_dt[c] = 0; m_hi[c] = 0; m_lo[c] = 0;
    end
  endtask

  task automatic model_step();
    bit wrap, latch;
    int dte;
    bit raw[CH];
    wrap  = ena && step && (m_cnt == CntMax);
    latch = wrap || (ena && !m_ena_q);
    dte   = latch ? int'(dead_time) : m_dt;
    for (int c = 0; c < CH; c++) raw[c] = (m_duty[c] == CntMax) || (m_cnt < m_duty[c]);
    for (int c = 0; c < CH; c++) begin
      if (!ena) begin
        m_hi[c] = 0; m_lo[c] = 0; m_off[c] = 1;
      end else begin
        if (m_off[c] || raw[c] != m_last[c]) begin
          m_last[c] = raw[c]; m_chg[c] = m_edge; m_chg_dt[c] = dte; m_off[c] = 0;
        end
        m_hi[c] = (m_edge - m_chg[c] >= m_chg_dt[c]) && m_last[c];
        m_lo[c] = (m_edge - m_chg[c] >= m_chg_dt[c]) && !m_last[c];
      end
    end
    if (latch) begin
      for (int c = 0; c < CH; c++) m_duty[c] = m_shadow[c];
      m_dt = dte;
    end
    if (duty_wr_valid && m_ready && int'(duty_wr_ch) < CH) m_shadow[duty_wr_ch] = int'(duty_wr_data);
    if (!ena) m_cnt = 0;
    else if (step) m_cnt = (m_cnt + 1) % (CntMax + 1);
    m_sync = wrap; m_ready = 1; m_ena_q = ena; m_edge++;
  endtask

  task automatic cycle();
    logic [CH-1:0] eh, el;
    if (step_div > 0) step = (cyc_cnt % step_div == 0);
    cyc_cnt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      eh[c] = m_hi[c]; el[c] = m_lo[c];
    end
    check_eq("pwm_hi", 32'(pwm_hi), 32'(eh));
    check_eq("pwm_lo", 32'(pwm_lo), 32'(el));
    check_eq("period_sync", 32'(period_sync), 32'(m_sync));
    check_eq("wr_ready", 32'(duty_wr_ready), 32'(m_ready));
    check_eq("hi_lo_overlap", 32'(pwm_hi & pwm_lo), 32'd0);
  endtask

  task automatic write_duty(input int ch, input int data);
    duty_wr_valid = 1'b1;
    duty_wr_ch    = 2'(ch);
    duty_wr_data  = 8'(data);
    cycle();
    duty_wr_valid = 1'b0;
  endtask

  task automatic wait_sync(input int limit);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!period_sync && n < limit);
    if (!period_sync) check_eq("sync_timeout", 32'(period_sync), 32'd1);
  endtask

  task automatic count_window(input int len, input int ch, output int hi_n, output int lo_n,
                              output int gap_n, output int sync_n);
    hi_n = 0; lo_n = 0; gap_n = 0; sync_n = 0;
    for (int k = 0; k < len; k++) begin
      cycle();
      hi_n   += int'(pwm_hi[ch]);
      lo_n   += int'(pwm_lo[ch]);
      gap_n  += int'(!pwm_hi[ch] && !pwm_lo[ch]);
      sync_n += int'(period_sync);
    end
  endtask

  task automatic random_cycles(input int len);
    int r;
    step_div = 0;
    for (int k = 0; k < len; k++) begin
      ena  = ($urandom_range(0, 99) != 0);
      step = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) dead_time = 4'($urandom_range(0, 15));
      duty_wr_valid = ($urandom_range(0, 31) == 0);
      duty_wr_ch    = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      duty_wr_data = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      cycle();
    end
    duty_wr_valid = 1'b0;
  endtask

  initial begin
    int hi_n, lo_n, gap_n, sync_n, n, hi1_n, lo2_n;
    rst_n = 1'b0; ena = 1'b1; step = 1'b1; dead_time = '0;
    duty_wr_valid = 1'b0; duty_wr_ch = '0; duty_wr_data = '0;
    step_div = 1; cyc_cnt = 0;
    model_reset();

    // Reset with ena/step high.
    repeat (3) @(negedge clk);
    check_eq("rst_hi", 32'(pwm_hi), 32'd0);
    check_eq("rst_lo", 32'(pwm_lo), 32'd0);
    check_eq("rst_sync", 32'(period_sync), 32'd0);
    check_eq("rst_ready", 32'(duty_wr_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    check_eq("ready_after_release", 32'(duty_wr_ready), 32'd1);

    // Duty 64, no dead time.
    write_duty(0, 64);
    wait_sync(600); wait_sync(600);
    count_window(256, 0, hi_n, lo_n, gap_n, sync_n);
    check_eq("d64_hi", hi_n, 64);
    check_eq("d64_lo", lo_n, 192);
    check_eq("d64_gap", gap_n, 0);
    check_eq("d64_sync", sync_n, 1);

    // Duty 128, dead time 3.
    dead_time = 4'd3;
    write_duty(0, 128);
    write_duty(1, 100);
    wait_sync(600); wait_sync(600);
    count_window(256, 0, hi_n, lo_n, gap_n, sync_n);
    check_eq("d128_hi", hi_n, 125);
    check_eq("d128_lo", lo_n, 125);
    check_eq("d128_gap", gap_n, 6);
    check_eq("d128_sync", sync_n, 1);

    // Mid-period writes on ch1 wait for the wrap.
    wait_sync(600);
    repeat (40) cycle();
    write_duty(1, 0);
    repeat (20) cycle();
    check_eq("ch1_old_duty_hi", 32'(pwm_hi[1]), 32'd1);
    wait_sync(600); wait_sync(600);
    count_window(256, 1, hi_n, lo_n, gap_n, sync_n);
    check_eq("d0_lo_const", lo_n, 256);
    check_eq("d0_hi_const", hi_n, 0);
    repeat (40) cycle();
    write_duty(1, 255);
    wait_sync(600); wait_sync(600);
    count_window(256, 1, hi_n, lo_n, gap_n, sync_n);
    check_eq("d255_hi_const", hi_n, 256);
    check_eq("d255_gap", gap_n, 0);

    // Drop ena at cnt=100, then raise it again.
    n = 0;
    while (m_cnt != 100 && n < 600) begin
      cycle();
      n++;
    end
    ena = 1'b0;
    cycle();
    check_eq("ena_drop_hi", 32'(pwm_hi), 32'd0);
    check_eq("ena_drop_lo", 32'(pwm_lo), 32'd0);
    repeat (4) cycle();
    ena = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!pwm_hi[0] && n < 20);
    check_eq("ena_rise_gap", n - 1, 3);

    // Step every 4th clk; out-of-range write is dropped.
    step_div = 4;
    write_duty(3, 10);
    wait_sync(1100); wait_sync(1100);
    n = 0; hi_n = 0; hi1_n = 0; lo2_n = 0;
    do begin
      cycle();
      n++;
      hi_n  += int'(pwm_hi[0]);
      hi1_n += int'(pwm_hi[1]);
      lo2_n += int'(pwm_lo[2]);
    end while (!period_sync && n < 1100);
    check_eq("slow_period", n, 1024);
    check_eq("slow_ch0_hi", hi_n, 509);
    check_eq("slow_ch1_hi", hi1_n, 1024);
    check_eq("slow_ch2_lo", lo2_n, 1024);

    random_cycles(3000);

    // Asynchronous reset mid-operation.
    ena = 1'b1;
    step_div = 1;
    repeat (300) cycle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_hi", 32'(pwm_hi), 32'd0);
    check_eq("async_rst_lo", 32'(pwm_lo), 32'd0);
    check_eq("async_rst_ready", 32'(duty_wr_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_hi", 32'(pwm_hi), 32'd0);
    check_eq("rst_hold_lo", 32'(pwm_lo), 32'd0);
    rst_n = 1'b1;
    random_cycles(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
